// File: rtl/prog_seq_controller.sv
// Programmable code sequencer: steps q through a DEPTH-entry table once per clock,
// either continuously or for a fixed number of passes. Start, stop and pause control the run.
module prog_seq_controller #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_len_we,
    input  logic [AW-1:0]    cfg_last,
    input  logic [7:0]       cfg_loops,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tbl [DEPTH];
    logic [AW-1:0]    last;
    logic [7:0]       loops;
    logic [7:0]       pass_cnt, pass_nxt, pass_inc;
    logic [WIDTH-1:0] q_nxt;
    logic [AW-1:0]    idx_nxt, idx_inc;
    logic             wrap_nxt, done_nxt, err_nxt;
    logic             cfg_any, tbl_wr, len_wr;

    function automatic logic [WIDTH-1:0] dflt(input int i);
        case (i)
            0:       return WIDTH'(1);
            1:       return WIDTH'(2);
            2:       return WIDTH'(3);
            3:       return WIDTH'(5);
            4:       return WIDTH'(9);
            5:       return WIDTH'(11);
            6:       return WIDTH'(12);
            7:       return WIDTH'(15);
            default: return '0;
        endcase
    endfunction

    assign cfg_any  = cfg_we | cfg_len_we;
    assign pass_inc = pass_cnt + 8'd1;
    assign idx_inc  = idx + AW'(1);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        idx_nxt   = idx;
        pass_nxt  = pass_cnt;
        wrap_nxt  = 1'b0;
        done_nxt  = 1'b0;
        // Config is only accepted while idle; any attempt during a run is flagged.
        err_nxt   = (state != IDLE) && cfg_any;
        tbl_wr    = (state == IDLE) && cfg_we;
        len_wr    = (state == IDLE) && cfg_len_we;
        case (state)
            IDLE: begin
                if (start && !stop && !cfg_any) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                    q_nxt     = tbl[0];
                    pass_nxt  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    q_nxt     = '0;
                    idx_nxt   = '0;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else if (idx < last) begin
                    idx_nxt = idx_inc;
                    q_nxt   = tbl[idx_inc];
                end else begin
                    wrap_nxt = 1'b1;
                    pass_nxt = pass_inc;
                    // On the final pass q/idx keep the last entry rather than rewinding.
                    if ((loops != 8'd0) && (pass_inc == loops)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = '0;
                        q_nxt   = tbl[0];
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    q_nxt     = '0;
                    idx_nxt   = '0;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            q        <= '0;
            idx      <= '0;
            pass_cnt <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            idx      <= idx_nxt;
            pass_cnt <= pass_nxt;
            wrap     <= wrap_nxt;
            done     <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= dflt(i);
            end
        end else if (tbl_wr) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last  <= AW'(DEPTH - 1);
            loops <= 8'd0;
        end else if (len_wr) begin
            last  <= cfg_last;
            loops <= cfg_loops;
        end
    end

endmodule

// File: tb/tb_prog_seq_controller.sv
// Directed bench for prog_seq_controller: per-cycle vector table plus hand-written
// pause and fixed-pass sequences.
module tb_prog_seq_controller;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_len_we, start, stop, pause;
    logic [2:0] cfg_addr, cfg_last;
    logic [3:0] cfg_data;
    logic [7:0] cfg_loops;
    logic [3:0] q;
    logic [2:0] idx;
    logic       busy, wrap, done, cfg_err;

    int errors = 0;
    int checks = 0;

    logic [3:0] dfl [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd12, 4'd15};
    logic [3:0] t2  [4] = '{4'd4, 4'd7, 4'd10, 4'd14};

    typedef struct {
        logic        r, s, sp, p, we;
        logic [2:0]  a;
        logic [3:0]  d;
        logic        lwe;
        logic [2:0]  l;
        logic [7:0]  lp;
        logic [10:0] e;
    } vec_t;

    vec_t vq[$];

    prog_seq_controller #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_last(cfg_last), .cfg_loops(cfg_loops),
        .start(start), .stop(stop), .pause(pause),
        .q(q), .idx(idx), .busy(busy), .wrap(wrap), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [3:0] eq, input logic [2:0] ei,
                                       input logic b, input logic w, input logic dn,
                                       input logic er);
        return {eq, ei, b, w, dn, er};
    endfunction

    task automatic wr(input logic twe, input logic [2:0] ta, input logic [3:0] td,
                      input logic tlwe, input logic [2:0] tl, input logic [7:0] tlp,
                      input logic ts, input logic tsp, input logic [10:0] te);
        vec_t v;
        v.r = 1'b0; v.s = ts; v.sp = tsp; v.p = 1'b0; v.we = twe; v.a = ta; v.d = td;
        v.lwe = tlwe; v.l = tl; v.lp = tlp; v.e = te;
        vq.push_back(v);
    endtask

    task automatic ctl(input logic tr, input logic ts, input logic tsp, input logic tp,
                       input logic [10:0] te);
        vec_t v;
        v.r = tr; v.s = ts; v.sp = tsp; v.p = tp; v.we = 1'b0; v.a = '0; v.d = '0;
        v.lwe = 1'b0; v.l = '0; v.lp = '0; v.e = te;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst = v.r; start = v.s; stop = v.sp; pause = v.p;
        cfg_we = v.we; cfg_addr = v.a; cfg_data = v.d;
        cfg_len_we = v.lwe; cfg_last = v.l; cfg_loops = v.lp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [10:0] e);
        logic [10:0] act;
        act = {q, idx, busy, wrap, done, cfg_err};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got q=%0d idx=%0d busy=%b wrap=%b done=%b err=%b, want q=%0d idx=%0d busy=%b wrap=%b done=%b err=%b",
                     nm, act[10:7], act[6:4], act[3], act[2], act[1], act[0],
                     e[10:7], e[6:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic hs(input string nm, input logic tr, input logic ts, input logic tsp,
                      input logic tp, input logic [10:0] te);
        rst = tr; start = ts; stop = tsp; pause = tp;
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        tick();
        check(nm, te);
    endtask

    task automatic cnt_check(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    initial begin
        int nb, nw, cyc;
        rst = 1'b1; start = 0; stop = 0; pause = 0; cfg_we = 0; cfg_len_we = 0;
        cfg_addr = '0; cfg_data = '0; cfg_last = '0; cfg_loops = '0;

        // Reset, then continuous default run across two wraps.
        ctl(1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 18; k++)
            ctl(0, k == 0, 0, 0, ex(dfl[k % 8], 3'(k % 8), 1, (k > 0) && (k % 8 == 0), 0, 0));
        ctl(0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0));
        ctl(0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0));
        // Program 4 entries, last=3, two passes.
        for (int i = 0; i < 4; i++)
            wr(1, 3'(i), t2[i], 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
        wr(0, 0, 0, 1, 3'd3, 8'd2, 0, 0, ex(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            ctl(0, k == 0, 0, 0, ex(t2[k % 4], 3'(k % 4), 1, k == 4, 0, 0));
        ctl(0, 0, 0, 0, ex(14, 3, 0, 1, 1, 0));
        ctl(0, 0, 0, 0, ex(14, 3, 0, 0, 0, 0));
        // last=0, three passes.
        wr(0, 0, 0, 1, 3'd0, 8'd3, 0, 0, ex(14, 3, 0, 0, 0, 0));
        ctl(0, 1, 0, 0, ex(4, 0, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(4, 0, 1, 1, 0, 0));
        ctl(0, 0, 0, 0, ex(4, 0, 1, 1, 0, 0));
        ctl(0, 0, 0, 0, ex(4, 0, 0, 1, 1, 0));
        ctl(0, 0, 0, 0, ex(4, 0, 0, 0, 0, 0));
        // Start alongside a length write: write lands, start ignored.
        wr(0, 0, 0, 1, 3'd3, 8'd0, 1, 0, ex(4, 0, 0, 0, 0, 0));
        // Writes while busy are rejected; accepted again once idle.
        ctl(0, 1, 0, 0, ex(4, 0, 1, 0, 0, 0));
        wr(1, 3'd0, 4'd6, 0, 0, 0, 0, 0, ex(7, 1, 1, 0, 0, 1));
        ctl(0, 0, 0, 0, ex(10, 2, 1, 0, 0, 0));
        ctl(0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0));
        wr(1, 3'd0, 4'd6, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
        ctl(0, 1, 0, 0, ex(6, 0, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(7, 1, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(10, 2, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(14, 3, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(6, 0, 1, 1, 0, 0));
        wr(0, 0, 0, 1, 3'd0, 8'd1, 0, 0, ex(7, 1, 1, 0, 0, 1));
        ctl(0, 0, 0, 0, ex(10, 2, 1, 0, 0, 0));
        // stop and start together: stop wins.
        ctl(0, 1, 1, 0, ex(0, 0, 0, 0, 0, 0));
        // rst mid-run restores table and length.
        ctl(0, 1, 0, 0, ex(6, 0, 1, 0, 0, 0));
        ctl(0, 0, 0, 0, ex(7, 1, 1, 0, 0, 0));
        ctl(1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
        ctl(0, 1, 0, 0, ex(1, 0, 1, 0, 0, 0));
        for (int k = 1; k < 5; k++)
            ctl(0, 0, 0, 0, ex(dfl[k], 3'(k), 1, 0, 0, 0));
        ctl(0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0));

        foreach (vq[i]) begin
            apply(vq[i]);
            tick();
            check($sformatf("vec%0d", i), vq[i].e);
        end

        // Pause for three cycles mid-sequence, then pause at the last entry.
        hs("p_rst",    1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
        hs("p_start",  0, 1, 0, 0, ex(1, 0, 1, 0, 0, 0));
        hs("p_q2",     0, 0, 0, 0, ex(2, 1, 1, 0, 0, 0));
        hs("p_q3",     0, 0, 0, 0, ex(3, 2, 1, 0, 0, 0));
        hs("p_q5",     0, 0, 0, 0, ex(5, 3, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            hs($sformatf("p_hold%0d", k), 0, 0, 0, 1, ex(5, 3, 1, 0, 0, 0));
        hs("p_resume", 0, 0, 0, 0, ex(5, 3, 1, 0, 0, 0));
        for (int k = 4; k < 8; k++)
            hs($sformatf("p_step%0d", k), 0, 0, 0, 0, ex(dfl[k], 3'(k), 1, 0, 0, 0));
        hs("p_at_last", 0, 0, 0, 1, ex(15, 7, 1, 0, 0, 0));
        hs("p_unpause", 0, 0, 0, 0, ex(15, 7, 1, 0, 0, 0));
        hs("p_wrap",    0, 0, 0, 0, ex(1, 0, 1, 1, 0, 0));
        hs("p_pause2",  0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0));
        hs("p_stop",    0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0));

        // Fixed-pass run: last=1, loops=4 -> busy 8 cycles, 4 wraps.
        rst = 0; stop = 0; pause = 0; start = 0;
        cfg_len_we = 1'b1; cfg_last = 3'd1; cfg_loops = 8'd4;
        tick();
        cfg_len_we = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        nb = busy ? 1 : 0;
        nw = 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (busy) nb++;
            if (wrap) nw++;
        end
        cnt_check("n_done_seen", int'(done), 1);
        cnt_check("n_busy_cycles", nb, 8);
        cnt_check("n_wraps", nw, 4);
        check("n_final", ex(2, 1, 0, 1, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
